// File: rtl/cm_responder.sv
// -----------------------------------------------------------------------------
// cm_responder
//
// Target (MCU-role) end of the CM byte-guessing protocol. It announces
// BEGIN_GUESSING on the shared CM bus, then clocks the initiator with
// CLK_inter and deframes START / guess / END frames sampled on each
// CLK_inter falling edge. Every well-formed frame is answered with YES or NO
// depending on whether the guess matches the secret latched at session start.
//
// Ports
//   CLK_50     in   1   sole clock
//   SW         in   1   SW[0] = synchronous active-high reset
//   start      in   1   level; begins a session when sampled in IDLE
//   SECRET     in   8   byte to be guessed, latched on session start
//   CLK_inter  out  1   registered interconnect clock to the initiator
//   CM         io   8   bidirectional protocol bus (via cm_bus_if)
//   LED        out  8   last captured guess byte
//   found      out  1   sticky: a YES was sent this session
//   timeout    out  1   sticky: HUNT gave up waiting for START
//   attempts   out 16   frames answered this session (saturating)
//   frame_err  out  8   framing errors this session (saturating)
// -----------------------------------------------------------------------------

// Tri-state buffer for the CM bus: drives i_data when i_oe, else releases.
module cm_bus_if (
    input  logic [7:0] i_data,
    input  logic       i_oe,
    output logic [7:0] o_data,
    inout  wire  [7:0] io_bus
);
    assign io_bus = i_oe ? i_data : 8'hzz;
    assign o_data = io_bus;
endmodule

module cm_responder #(
    parameter int HALF_PERIOD     = 25,
    parameter int ANNOUNCE_CYCLES = 16,
    parameter int TURNAROUND      = 2,
    parameter int REPLY_CYCLES    = 8,
    parameter int TIMEOUT_PULSES  = 64
) (
    input  logic        CLK_50,
    input  logic [0:0]  SW,
    input  logic        start,
    input  logic [7:0]  SECRET,
    output logic        CLK_inter,
    inout  wire  [7:0]  CM,
    output logic [7:0]  LED,
    output logic        found,
    output logic        timeout,
    output logic [15:0] attempts,
    output logic [7:0]  frame_err
);

    // Protocol bytes
    localparam logic [7:0] BYTE_START = 8'h01;
    localparam logic [7:0] BYTE_BEGIN = 8'h02;
    localparam logic [7:0] BYTE_YES   = 8'h03;
    localparam logic [7:0] BYTE_NO    = 8'h04;
    localparam logic [7:0] BYTE_END   = 8'h05;

    // FSM states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ANNOUNCE  = 3'd1;
    localparam logic [2:0] S_GAP1      = 3'd2;
    localparam logic [2:0] S_HUNT      = 3'd3;
    localparam logic [2:0] S_GOT_START = 3'd4;
    localparam logic [2:0] S_GOT_DATA  = 3'd5;
    localparam logic [2:0] S_GAP2      = 3'd6;
    localparam logic [2:0] S_REPLY     = 3'd7;

    // Terminal counts. Gaps compare against TURNAROUND (not TURNAROUND-1) so
    // the bus stays released for the whole turnaround window after the edge
    // that ended the previous phase.
    localparam logic [15:0] HP_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] AC_LAST = 16'(ANNOUNCE_CYCLES - 1);
    localparam logic [15:0] TA_LAST = 16'(TURNAROUND);
    localparam logic [15:0] RC_LAST = 16'(REPLY_CYCLES - 1);
    localparam logic [15:0] TP_LAST = 16'(TIMEOUT_PULSES - 1);

    // Saturating increments for the session statistics.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = v;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_phase;
    logic [15:0] r_to_cnt;
    logic        r_clk_inter;
    logic        r_drive_en;
    logic [7:0]  r_drive_data;
    logic [7:0]  r_secret;
    logic [7:0]  r_led;
    logic        r_found;
    logic        r_timeout;
    logic [15:0] r_attempts;
    logic [7:0]  r_frame_err;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;

    logic [7:0]  w_cm_in;
    logic        w_clocking;
    logic        w_fall;
    logic        w_rst;

    assign w_rst = SW[0];

    cm_bus_if u_bus (
        .i_data (r_drive_data),
        .i_oe   (r_drive_en),
        .o_data (w_cm_in),
        .io_bus (CM)
    );

    // Decode clocking states and the cycle on which CLK_inter is driven low.
    always_comb begin
        w_clocking = 1'b0;
        w_fall     = 1'b0;
        if ((r_state == S_HUNT) || (r_state == S_GOT_START) || (r_state == S_GOT_DATA)) begin
            w_clocking = 1'b1;
            w_fall     = r_clk_inter && (r_phase == HP_LAST);
        end else begin
            w_clocking = 1'b0;
            w_fall     = 1'b0;
        end
    end

    // Two-flop synchronizer on the incoming CM bus.
    always_ff @(posedge CLK_50) begin
        if (w_rst) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= w_cm_in;
            r_sync2 <= r_sync1;
        end
    end

    // CLK_inter generator: starts high on HUNT entry, toggles every
    // HALF_PERIOD cycles while clocking. Every exit from the clocking states
    // happens on a falling edge, so the clock is never cut short while high.
    always_ff @(posedge CLK_50) begin
        if (w_rst) begin
            r_clk_inter <= 1'b0;
            r_phase     <= 16'd0;
        end else if ((r_state == S_GAP1) && (r_cnt == TA_LAST)) begin
            r_clk_inter <= 1'b1;
            r_phase     <= 16'd0;
        end else if (w_clocking) begin
            if (r_phase == HP_LAST) begin
                r_clk_inter <= ~r_clk_inter;
                r_phase     <= 16'd0;
            end else begin
                r_phase     <= r_phase + 16'd1;
            end
        end else begin
            r_clk_inter <= 1'b0;
            r_phase     <= 16'd0;
        end
    end

    // Protocol FSM, bus drive control and session statistics.
    always_ff @(posedge CLK_50) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_to_cnt     <= 16'd0;
            r_drive_en   <= 1'b0;
            r_drive_data <= 8'h00;
            r_secret     <= 8'h00;
            r_led        <= 8'h00;
            r_found      <= 1'b0;
            r_timeout    <= 1'b0;
            r_attempts   <= 16'd0;
            r_frame_err  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drive_en <= 1'b0;
                    if (start) begin
                        r_secret     <= SECRET;
                        r_found      <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_attempts   <= 16'd0;
                        r_frame_err  <= 8'd0;
                        r_cnt        <= 16'd0;
                        r_drive_en   <= 1'b1;
                        r_drive_data <= BYTE_BEGIN;
                        r_state      <= S_ANNOUNCE;
                    end else begin
                        r_state      <= S_IDLE;
                    end
                end
                S_ANNOUNCE: begin
                    if (r_cnt == AC_LAST) begin
                        r_drive_en <= 1'b0;
                        r_cnt      <= 16'd0;
                        r_state    <= S_GAP1;
                    end else begin
                        r_cnt      <= r_cnt + 16'd1;
                    end
                end
                S_GAP1: begin
                    if (r_cnt == TA_LAST) begin
                        r_cnt    <= 16'd0;
                        r_to_cnt <= 16'd0;
                        r_state  <= S_HUNT;
                    end else begin
                        r_cnt    <= r_cnt + 16'd1;
                    end
                end
                S_HUNT: begin
                    if (w_fall) begin
                        if (r_sync2 == BYTE_START) begin
                            r_to_cnt <= 16'd0;
                            r_state  <= S_GOT_START;
                        end else if (r_to_cnt == TP_LAST) begin
                            r_timeout <= 1'b1;
                            r_to_cnt  <= 16'd0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end else begin
                        r_state <= S_HUNT;
                    end
                end
                S_GOT_START: begin
                    // The byte after START is the guess, whatever its value.
                    if (w_fall) begin
                        r_led   <= r_sync2;
                        r_state <= S_GOT_DATA;
                    end else begin
                        r_state <= S_GOT_START;
                    end
                end
                S_GOT_DATA: begin
                    if (w_fall) begin
                        if (r_sync2 == BYTE_END) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_GAP2;
                        end else begin
                            // Malformed frame: keep clocking and hunt again.
                            r_frame_err <= sat_inc8(r_frame_err);
                            r_to_cnt    <= 16'd0;
                            r_state     <= S_HUNT;
                        end
                    end else begin
                        r_state <= S_GOT_DATA;
                    end
                end
                S_GAP2: begin
                    if (r_cnt == TA_LAST) begin
                        r_cnt        <= 16'd0;
                        r_drive_en   <= 1'b1;
                        r_drive_data <= (r_led == r_secret) ? BYTE_YES : BYTE_NO;
                        r_attempts   <= sat_inc16(r_attempts);
                        r_state      <= S_REPLY;
                    end else begin
                        r_cnt        <= r_cnt + 16'd1;
                    end
                end
                S_REPLY: begin
                    if (r_cnt == RC_LAST) begin
                        r_drive_en <= 1'b0;
                        r_cnt      <= 16'd0;
                        if (r_drive_data == BYTE_YES) begin
                            r_found <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GAP1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_drive_en <= 1'b0;
                    r_cnt      <= 16'd0;
                end
            endcase
        end
    end

    assign CLK_inter = r_clk_inter;
    assign LED       = r_led;
    assign found     = r_found;
    assign timeout   = r_timeout;
    assign attempts  = r_attempts;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_cm_responder.sv
// Self-checking bench for cm_responder. A small initiator model drives frames
// on CM; expected bus drives from the responder (announce / reply bytes and
// their lengths) are queued at stimulus time and compared by a monitor.
module tb_cm_responder;

    localparam int HP  = 4;
    localparam int TA  = 2;
    localparam int AC  = 16;
    localparam int RC  = 8;
    localparam int TP  = 64;

    logic        CLK_50 = 1'b0;
    logic [0:0]  SW;
    logic        start;
    logic [7:0]  SECRET;
    wire         CLK_inter;
    wire  [7:0]  CM;
    wire  [7:0]  LED;
    wire         found;
    wire         timeout;
    wire  [15:0] attempts;
    wire  [7:0]  frame_err;

    logic        tb_oe;
    logic [7:0]  tb_data;

    assign CM = tb_oe ? tb_data : 8'hzz;

    always #5 CLK_50 = ~CLK_50;

    cm_responder #(
        .HALF_PERIOD     (HP),
        .ANNOUNCE_CYCLES (AC),
        .TURNAROUND      (TA),
        .REPLY_CYCLES    (RC),
        .TIMEOUT_PULSES  (TP)
    ) dut (
        .CLK_50    (CLK_50),
        .SW        (SW),
        .start     (start),
        .SECRET    (SECRET),
        .CLK_inter (CLK_inter),
        .CM        (CM),
        .LED       (LED),
        .found     (found),
        .timeout   (timeout),
        .attempts  (attempts),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0] val;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] v, input int l);
        exp_t e;
        e.val = v;
        e.len = l;
        exp_q.push_back(e);
    endtask

    // Monitor: tracks CLK_inter falls and checks every responder drive.
    logic mon_prev_ci  = 1'b0;
    logic mon_drv_prev = 1'b0;
    int   since_fall   = 0;
    int   mon_len      = 0;
    logic cur_valid    = 1'b0;

    always @(negedge CLK_50) begin
        if (mon_prev_ci && !CLK_inter) since_fall = 0;
        else since_fall++;
        mon_prev_ci = CLK_inter;

        if (dut.r_drive_en && !mon_drv_prev) begin
            check("no_overlap", {31'd0, tb_oe}, 32'd0);
            if (exp_q.size() == 0) begin
                n_total++;
                cur_valid = 1'b0;
                $display("FAIL unexpected_drive: got %0h expected none", CM);
            end else begin
                cur = exp_q.pop_front();
                cur_valid = 1'b1;
                check("drive_byte", {24'd0, CM}, {24'd0, cur.val});
                if (cur.val != 8'h02) check("reply_latency", since_fall, TA + 1);
            end
            mon_len = 1;
        end else if (dut.r_drive_en) begin
            mon_len++;
        end else if (mon_drv_prev && cur_valid) begin
            check("drive_len", mon_len, cur.len);
        end
        mon_drv_prev = dut.r_drive_en;
    end

    // Wait for a CLK_inter edge (rising or falling), bounded.
    task automatic wait_edge(input bit rising);
        logic p;
        p = CLK_inter;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK_50);
            if (rising ? (CLK_inter && !p) : (!CLK_inter && p)) return;
            p = CLK_inter;
        end
        n_total++;
        $display("FAIL edge_wait: got no %s edge expected one", rising ? "rising" : "falling");
    endtask

    // Initiator model: present one byte from a rise until the sampling fall.
    task automatic send_byte(input logic [7:0] b);
        wait_edge(1'b1);
        tb_oe   = 1'b1;
        tb_data = b;
        wait_edge(1'b0);
    endtask

    // Full frame; bus released right at the END-sampling fall.
    task automatic send_frame(input logic [7:0] g, input logic [7:0] reply);
        send_byte(8'h01);
        send_byte(g);
        send_byte(8'h05);
        tb_oe = 1'b0;
        push_exp(reply, RC);
    endtask

    task automatic begin_session(input logic [7:0] sec);
        @(negedge CLK_50);
        SECRET = sec;
        start  = 1'b1;
        push_exp(8'h02, AC);
        @(negedge CLK_50);
        start  = 1'b0;
    endtask

    task automatic wait_found();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK_50);
            if (found) return;
        end
        n_total++;
        $display("FAIL found_wait: got found=0 expected 1");
    endtask

    int falls;
    logic pci;

    initial begin
        SW      = 1'b1;
        start   = 1'b0;
        SECRET  = 8'h00;
        tb_oe   = 1'b0;
        tb_data = 8'h00;
        repeat (4) @(negedge CLK_50);
        check("rst_clk_inter", {31'd0, CLK_inter}, 32'd0);
        check("rst_led",       {24'd0, LED}, 32'd0);
        check("rst_found",     {31'd0, found}, 32'd0);
        check("rst_timeout",   {31'd0, timeout}, 32'd0);
        check("rst_attempts",  {16'd0, attempts}, 32'd0);
        check("rst_frame_err", {24'd0, frame_err}, 32'd0);
        check("rst_drive",     {31'd0, dut.r_drive_en}, 32'd0);
        SW = 1'b0;
        repeat (2) @(negedge CLK_50);

        // Three guesses: NO, NO, YES.
        begin_session(8'h08);
        send_frame(8'h06, 8'h04);
        send_frame(8'h07, 8'h04);
        send_frame(8'h08, 8'h03);
        wait_found();
        repeat (3) @(negedge CLK_50);
        check("t1_attempts",  {16'd0, attempts}, 32'd3);
        check("t1_found",     {31'd0, found}, 32'd1);
        check("t1_led",       {24'd0, LED}, 32'h08);
        check("t1_clk_inter", {31'd0, CLK_inter}, 32'd0);

        // Bad frame (no END) then a good one.
        begin_session(8'h08);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h07);
        send_frame(8'h08, 8'h03);
        wait_found();
        repeat (3) @(negedge CLK_50);
        check("t2_frame_err", {24'd0, frame_err}, 32'd1);
        check("t2_attempts",  {16'd0, attempts}, 32'd1);
        check("t2_found",     {31'd0, found}, 32'd1);

        // Bus held at 00: timeout after exactly TP falls.
        begin_session(8'h08);
        wait_edge(1'b1);
        tb_oe   = 1'b1;
        tb_data = 8'h00;
        falls   = 0;
        pci     = CLK_inter;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK_50);
            if (pci && !CLK_inter) falls++;
            pci = CLK_inter;
            if (timeout) break;
        end
        check("t3_falls", falls, TP);
        check("t3_timeout", {31'd0, timeout}, 32'd1);
        tb_oe = 1'b0;
        repeat (20) @(negedge CLK_50);
        check("t3_clk_inter", {31'd0, CLK_inter}, 32'd0);
        check("t3_released",  {31'd0, dut.r_drive_en}, 32'd0);
        check("t3_attempts",  {16'd0, attempts}, 32'd0);

        // Noise before a frame; start and SECRET changes mid-session ignored.
        begin_session(8'h33);
        send_byte(8'h00);
        SECRET = 8'h44;
        start  = 1'b1;
        send_byte(8'hFF);
        send_byte(8'h33);
        send_byte(8'h01);
        send_byte(8'h33);
        start  = 1'b0;
        send_byte(8'h05);
        tb_oe  = 1'b0;
        push_exp(8'h03, RC);
        wait_found();
        repeat (3) @(negedge CLK_50);
        check("t4_attempts",  {16'd0, attempts}, 32'd1);
        check("t4_timeout",   {31'd0, timeout}, 32'd0);
        check("t4_frame_err", {24'd0, frame_err}, 32'd0);
        check("t4_led",       {24'd0, LED}, 32'h33);

        // Reset while in GOT_START.
        begin_session(8'h08);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h07);
        send_byte(8'h01);
        SW = 1'b1;
        @(negedge CLK_50);
        check("t5_clk_inter", {31'd0, CLK_inter}, 32'd0);
        check("t5_released",  {31'd0, dut.r_drive_en}, 32'd0);
        check("t5_frame_err", {24'd0, frame_err}, 32'd0);
        check("t5_led",       {24'd0, LED}, 32'd0);
        check("t5_attempts",  {16'd0, attempts}, 32'd0);
        tb_oe = 1'b0;
        SW    = 1'b0;
        repeat (2) @(negedge CLK_50);
        begin_session(8'h08);
        repeat (AC + 4) @(negedge CLK_50);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
